mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbiter that shares one single-ported memory interface between the core's instruction bus (ibus) and data bus (dbus). It sits between `riscv_ic` and the memory model/controller inside the SoC top. It serialises requests through a registered grant state machine, returns read data with a one-cycle ready pulse, and bounds starvation and memory-hang cases with a streak limiter and a timeout.

## Interface
Parameters:
- `MAX_DBUS_STREAK`, default 4: maximum consecutive contended dbus grants before ibus is forced a grant (range 1..15).
- `TIMEOUT`, default 255: number of cycles in GRANT before the arbiter aborts the transaction (range 1..255).
- `ERR_DATA`, default 32'hDEAD_BEEF: read data returned on timeout.

Ports (clock is `clk`; reset is `rst`, asynchronous, active-high):
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous active-high reset.
- `I_ibus_req`, `I_ibus_we`  in  1  ibus request and write enable.
- `I_ibus_addr`, `I_ibus_data`  in  32  ibus address and write data.
- `I_ibus_mask`  in  4  ibus byte mask.
- `O_ibus_data`  out  32  ibus read data; valid while `O_ibus_ready`=1.
- `O_ibus_ready`  out  1  one-cycle completion pulse for ibus.
- `I_dbus_req`, `I_dbus_we`, `I_dbus_addr`, `I_dbus_data`, `I_dbus_mask`  in  1/1/32/32/4  dbus request fields, same meaning as the ibus fields.
- `O_dbus_data`, `O_dbus_ready`  out  32/1  dbus read data and completion pulse.
- `O_mem_req`, `O_mem_we`  out  1  memory-side request and write enable.
- `O_mem_addr`, `O_mem_data`  out  32  memory-side address and write data.
- `O_mem_mask`  out  4  memory-side byte mask.
- `I_mem_data`  in  32  memory read data.
- `I_mem_ready`  in  1  memory completion; sampled only while `O_mem_req`=1.
- `O_err`  out  1  one-cycle pulse when a transaction times out.

## Operation
- States: IDLE, GRANT_I, GRANT_D, RESP.
- IDLE transitions:
  - If neither request is active, stay in IDLE.
  - If only one request is active, grant it.
  - If both are active, grant dbus unless `streak` == `MAX_DBUS_STREAK`; in that case grant ibus.
  - On grant, register the winner's we/addr/data/mask into the mem-side output registers and move to GRANT_I or GRANT_D.
- `streak` counter (4 bits):
  - Increments on each dbus grant made while ibus was also requesting; saturates at `MAX_DBUS_STREAK`.
  - Clears on any ibus grant.
  - Holds its value on an uncontended dbus grant.
- GRANT_x behaviour:
  - `O_mem_req`=1 and the mem-side payload is held constant.
  - On `I_mem_ready`=1: latch `I_mem_data` into `O_x_data` and go to RESP with `O_x_ready`=1.
  - Otherwise increment the timeout counter. If the counter reaches `TIMEOUT`: latch `ERR_DATA`, pulse `O_err` together with `O_x_ready`, and go to RESP.
- RESP lasts exactly one cycle; `O_x_ready`=1 for the granted side only, then go to IDLE.
  - The transaction is complete here. A `req` still high in this cycle is not arbitrated.
  - A `req` still high in the following IDLE cycle is treated as a new transaction.
- Requesters hold `req` and the payload stable until they see `ready`. The arbiter samples the payload only in the IDLE grant cycle.
- `O_x_data` holds its last value outside RESP. For writes it carries whatever `I_mem_data` was at completion; requesters ignore it.
- The timeout counter is 8 bits and clears on every grant.

## Timing
- Reset values: state IDLE; `streak`=0; timeout counter=0; `O_mem_req`/`O_mem_we`=0; `O_mem_addr`/`O_mem_data`=0; `O_mem_mask`=0; both `O_x_ready`=0; both `O_x_data`=0; `O_err`=0.
- Reset asserted mid-transaction drops `O_mem_req` asynchronously and abandons the transaction; no ready pulse is issued for it.
- Cycle numbering, for a `req` seen in IDLE at cycle 0:
  - `O_mem_req`=1 from cycle 1.
  - With `I_mem_ready`=1 in cycle k (k ≥ 1), `O_x_ready`=1 in cycle k+1 and the state is IDLE in cycle k+2.
  - Minimum latency is 2 cycles; maximum back-to-back throughput is one transaction per 3 cycles.
- Timeout: with no `I_mem_ready`, `O_err` and `O_x_ready` pulse in cycle `TIMEOUT`+1.
- `I_mem_ready` in the same cycle the counter reaches `TIMEOUT`: normal completion wins, and `O_err` stays 0.
- `I_mem_ready` outside the GRANT states is ignored.
- All outputs are registered. There are no combinational paths from any input to any output.

## Test plan
- Single ibus read, addr 0x8000_0000, memory ready 1 cycle after `O_mem_req` -> `O_mem_req` high in cycles 1–2; `O_ibus_ready` in cycle 3 with `O_ibus_data` = memory word; `O_dbus_ready` stays 0.
- dbus write, addr 0x8000_0100, data 0x1234_5678, mask 4'b0011 -> `O_mem_we`=1 with matching addr/data/mask held for the whole GRANT; one `O_dbus_ready` pulse.
- Both requests held continuously, memory ready immediately, `MAX_DBUS_STREAK`=4 -> grant order D,D,D,D,I,D,D,D,D,I…; `streak` clears after each I grant.
- Memory never asserts ready, `TIMEOUT`=255 -> `O_err`=1, `O_dbus_ready`=1, `O_dbus_data`=0xDEAD_BEEF in cycle 256; next transaction proceeds normally.
- `I_mem_ready` at exactly the timeout count -> normal data returned, `O_err`=0.
- Assert `rst` during GRANT_D -> `O_mem_req` falls immediately; no ready pulse; after release, a fresh ibus request completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory interface between the
// instruction bus and the data bus. Requests are serialised through a
// registered grant FSM; read data comes back with a one-cycle ready pulse.
// A dbus streak limiter keeps ibus from starving, and a timeout keeps a
// silent memory from hanging either requester.
//
// state   | meaning
// IDLE    | arbitrate; latch the winner's payload into the mem-side registers
// GRANT_I | ibus transaction outstanding on the memory port
// GRANT_D | dbus transaction outstanding on the memory port
// RESP    | one-cycle ready pulse to the granted side, no arbitration
module mem_port_arbiter #(
    parameter int unsigned MAX_DBUS_STREAK = 4,
    parameter int unsigned TIMEOUT         = 255,
    parameter logic [31:0] ERR_DATA        = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        I_ibus_req,
    input  logic        I_ibus_we,
    input  logic [31:0] I_ibus_addr,
    input  logic [31:0] I_ibus_data,
    input  logic [3:0]  I_ibus_mask,
    output logic [31:0] O_ibus_data,
    output logic        O_ibus_ready,
    input  logic        I_dbus_req,
    input  logic        I_dbus_we,
    input  logic [31:0] I_dbus_addr,
    input  logic [31:0] I_dbus_data,
    input  logic [3:0]  I_dbus_mask,
    output logic [31:0] O_dbus_data,
    output logic        O_dbus_ready,
    output logic        O_mem_req,
    output logic        O_mem_we,
    output logic [31:0] O_mem_addr,
    output logic [31:0] O_mem_data,
    output logic [3:0]  O_mem_mask,
    input  logic [31:0] I_mem_data,
    input  logic        I_mem_ready,
    output logic        O_err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT_I = 2'd1,
        S_GRANT_D = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DBUS_STREAK);
    localparam logic [7:0] TMO_LIMIT  = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic [3:0]  streak_q, streak_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_data_q, mem_data_d;
    logic [3:0]  mem_mask_q, mem_mask_d;
    logic [31:0] ibus_data_q, ibus_data_d;
    logic        ibus_ready_q, ibus_ready_d;
    logic [31:0] dbus_data_q, dbus_data_d;
    logic        dbus_ready_q, dbus_ready_d;
    logic        err_q, err_d;
    logic        grant_d_win;
    logic        tmo_hit;

    // dbus wins a contended IDLE cycle unless it has used up its streak
    assign grant_d_win = I_dbus_req && !(I_ibus_req && (streak_q == STREAK_MAX));
    assign tmo_hit     = (tmo_q + 8'd1) == TMO_LIMIT;

    // Next-state and next-output computation for the grant FSM
    always_comb begin
        state_d      = state_q;
        streak_d     = streak_q;
        tmo_d        = tmo_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        mem_mask_d   = mem_mask_q;
        ibus_data_d  = ibus_data_q;
        ibus_ready_d = 1'b0;
        dbus_data_d  = dbus_data_q;
        dbus_ready_d = 1'b0;
        err_d        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (grant_d_win) begin
                    state_d    = S_GRANT_D;
                    mem_req_d  = 1'b1;
                    mem_we_d   = I_dbus_we;
                    mem_addr_d = I_dbus_addr;
                    mem_data_d = I_dbus_data;
                    mem_mask_d = I_dbus_mask;
                    tmo_d      = 8'd0;
                    // contended win only happens below the limit, so +1 saturates at the limit
                    if (I_ibus_req) begin
                        streak_d = streak_q + 4'd1;
                    end
                end else if (I_ibus_req) begin
                    state_d    = S_GRANT_I;
                    mem_req_d  = 1'b1;
                    mem_we_d   = I_ibus_we;
                    mem_addr_d = I_ibus_addr;
                    mem_data_d = I_ibus_data;
                    mem_mask_d = I_ibus_mask;
                    tmo_d      = 8'd0;
                    streak_d   = 4'd0;
                end
            end
            S_GRANT_I, S_GRANT_D: begin
                if (I_mem_ready || tmo_hit) begin
                    // a ready arriving on the final count still counts as a normal completion
                    state_d   = S_RESP;
                    mem_req_d = 1'b0;
                    err_d     = !I_mem_ready;
                    if (state_q == S_GRANT_I) begin
                        ibus_ready_d = 1'b1;
                        ibus_data_d  = I_mem_ready ? I_mem_data : ERR_DATA;
                    end else begin
                        dbus_ready_d = 1'b1;
                        dbus_data_d  = I_mem_ready ? I_mem_data : ERR_DATA;
                    end
                end
                if (!I_mem_ready) begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered-output update with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            streak_q     <= 4'd0;
            tmo_q        <= 8'd0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_data_q   <= 32'd0;
            mem_mask_q   <= 4'd0;
            ibus_data_q  <= 32'd0;
            ibus_ready_q <= 1'b0;
            dbus_data_q  <= 32'd0;
            dbus_ready_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            streak_q     <= streak_d;
            tmo_q        <= tmo_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            mem_mask_q   <= mem_mask_d;
            ibus_data_q  <= ibus_data_d;
            ibus_ready_q <= ibus_ready_d;
            dbus_data_q  <= dbus_data_d;
            dbus_ready_q <= dbus_ready_d;
            err_q        <= err_d;
        end
    end

    assign O_mem_req    = mem_req_q;
    assign O_mem_we     = mem_we_q;
    assign O_mem_addr   = mem_addr_q;
    assign O_mem_data   = mem_data_q;
    assign O_mem_mask   = mem_mask_q;
    assign O_ibus_data  = ibus_data_q;
    assign O_ibus_ready = ibus_ready_q;
    assign O_dbus_data  = dbus_data_q;
    assign O_dbus_ready = dbus_ready_q;
    assign O_err        = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: table of single transactions, streak and
// reset sequences, then random traffic against a timestamp-level model.
module tb_mem_port_arbiter;

    localparam int MAXS = 4;

    logic        clk;
    logic        rst;
    logic        I_ibus_req, I_ibus_we;
    logic [31:0] I_ibus_addr, I_ibus_data;
    logic [3:0]  I_ibus_mask;
    logic [31:0] O_ibus_data;
    logic        O_ibus_ready;
    logic        I_dbus_req, I_dbus_we;
    logic [31:0] I_dbus_addr, I_dbus_data;
    logic [3:0]  I_dbus_mask;
    logic [31:0] O_dbus_data;
    logic        O_dbus_ready;
    logic        O_mem_req, O_mem_we;
    logic [31:0] O_mem_addr, O_mem_data;
    logic [3:0]  O_mem_mask;
    logic [31:0] I_mem_data;
    logic        I_mem_ready;
    logic        O_err;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .I_ibus_req   (I_ibus_req),
        .I_ibus_we    (I_ibus_we),
        .I_ibus_addr  (I_ibus_addr),
        .I_ibus_data  (I_ibus_data),
        .I_ibus_mask  (I_ibus_mask),
        .O_ibus_data  (O_ibus_data),
        .O_ibus_ready (O_ibus_ready),
        .I_dbus_req   (I_dbus_req),
        .I_dbus_we    (I_dbus_we),
        .I_dbus_addr  (I_dbus_addr),
        .I_dbus_data  (I_dbus_data),
        .I_dbus_mask  (I_dbus_mask),
        .O_dbus_data  (O_dbus_data),
        .O_dbus_ready (O_dbus_ready),
        .O_mem_req    (O_mem_req),
        .O_mem_we     (O_mem_we),
        .O_mem_addr   (O_mem_addr),
        .O_mem_data   (O_mem_data),
        .O_mem_mask   (O_mem_mask),
        .I_mem_data   (I_mem_data),
        .I_mem_ready  (I_mem_ready),
        .O_err        (O_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          ireq;
        bit          dreq;
        bit          iwe;
        logic [31:0] iaddr;
        logic [31:0] idata;
        logic [3:0]  imask;
        bit          dwe;
        logic [31:0] daddr;
        logic [31:0] ddata;
        logic [3:0]  dmask;
        int          mem_k;
        logic [31:0] mem_word;
        bit          exp_i;
        int          exp_rc;
        logic [31:0] exp_data;
        bit          exp_err;
    } vec_t;

    vec_t tbl [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        I_ibus_req = 1'b0; I_ibus_we = 1'b0; I_ibus_addr = 32'd0; I_ibus_data = 32'd0; I_ibus_mask = 4'd0;
        I_dbus_req = 1'b0; I_dbus_we = 1'b0; I_dbus_addr = 32'd0; I_dbus_data = 32'd0; I_dbus_mask = 4'd0;
        I_mem_ready = 1'b0; I_mem_data = 32'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        chk("reset_ctrl", 128'({O_mem_req, O_mem_we, O_mem_addr, O_mem_data, O_mem_mask,
                                O_ibus_ready, O_dbus_ready, O_err}), 128'(0));
        chk("reset_rdata", 128'({O_ibus_data, O_dbus_data}), 128'(0));
        tick();
        rst = 1'b0;
    endtask

    task automatic rand_ipay();
        I_ibus_we = 1'($urandom); I_ibus_addr = $urandom; I_ibus_data = $urandom; I_ibus_mask = 4'($urandom);
    endtask

    task automatic rand_dpay();
        I_dbus_we = 1'($urandom); I_dbus_addr = $urandom; I_dbus_data = $urandom; I_dbus_mask = 4'($urandom);
    endtask

    // Current cycle is cycle 0 (arbiter in IDLE); runs until one cycle past the ready pulse.
    task automatic run_vec(input vec_t v, input string tag);
        logic [68:0] pay;
        pay = v.exp_i ? {v.iwe, v.iaddr, v.idata, v.imask} : {v.dwe, v.daddr, v.ddata, v.dmask};
        I_ibus_req = v.ireq; I_ibus_we = v.iwe; I_ibus_addr = v.iaddr; I_ibus_data = v.idata; I_ibus_mask = v.imask;
        I_dbus_req = v.dreq; I_dbus_we = v.dwe; I_dbus_addr = v.daddr; I_dbus_data = v.ddata; I_dbus_mask = v.dmask;
        I_mem_ready = 1'b1;
        I_mem_data  = $urandom;
        for (int c = 1; c <= v.exp_rc + 1; c++) begin
            tick();
            if (c < v.exp_rc) begin
                chk({tag, "_mreq"}, 128'(O_mem_req), 128'(1));
                chk({tag, "_payload"}, 128'({O_mem_we, O_mem_addr, O_mem_data, O_mem_mask}), 128'(pay));
                chk({tag, "_early"}, 128'({O_ibus_ready, O_dbus_ready, O_err}), 128'(0));
            end else if (c == v.exp_rc) begin
                chk({tag, "_ready"}, 128'({O_ibus_ready, O_dbus_ready}), 128'({v.exp_i, !v.exp_i}));
                chk({tag, "_err"}, 128'(O_err), 128'(v.exp_err));
                chk({tag, "_rdata"}, 128'(v.exp_i ? O_ibus_data : O_dbus_data), 128'(v.exp_data));
                chk({tag, "_mreq_drop"}, 128'(O_mem_req), 128'(0));
            end else begin
                chk({tag, "_after"}, 128'({O_mem_req, O_ibus_ready, O_dbus_ready, O_err}), 128'(0));
            end
            I_mem_ready = (c == v.mem_k) || (c >= v.exp_rc);
            I_mem_data  = (c == v.mem_k) ? v.mem_word : $urandom;
            if (c == v.exp_rc) begin
                I_ibus_req = 1'b0;
                I_dbus_req = 1'b0;
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          g;
        int          last;
        logic        prev;
        bit          pend_i, pend_d, active, win_i, rdy;
        bit          exp_mreq, exp_ir, exp_dr;
        logic [31:0] exp_idata, exp_ddata;
        logic [68:0] exp_pay;
        int          avail, dcnt, gstart, glat;
        vec_t        fresh;

        //           ireq dreq iwe iaddr          idata          imask  dwe daddr          ddata          dmask    k    word           exp_i rc   data           err
        tbl[0] = '{1, 0, 0, 32'h8000_0000, 32'h0,         4'hF,  0, 32'h0,         32'h0,         4'h0,    2,   32'hCAFE_0001, 1,    3,   32'hCAFE_0001, 0};
        tbl[1] = '{0, 1, 0, 32'h0,         32'h0,         4'h0,  1, 32'h8000_0100, 32'h1234_5678, 4'b0011, 1,   32'h0000_5555, 0,    2,   32'h0000_5555, 0};
        tbl[2] = '{1, 1, 0, 32'h8000_0010, 32'h0,         4'hF,  0, 32'h8000_0200, 32'h0,         4'hF,    1,   32'h1111_2222, 0,    2,   32'h1111_2222, 0};
        tbl[3] = '{0, 1, 0, 32'h0,         32'h0,         4'h0,  0, 32'h8000_0300, 32'h0,         4'hF,    4,   32'h3333_4444, 0,    5,   32'h3333_4444, 0};
        tbl[4] = '{1, 0, 1, 32'h8000_0020, 32'hA5A5_5A5A, 4'hF,  0, 32'h0,         32'h0,         4'h0,    3,   32'h0,         1,    4,   32'h0,         0};
        tbl[5] = '{1, 1, 0, 32'h8000_0030, 32'h0,         4'hF,  1, 32'h8000_0500, 32'hFFFF_0000, 4'b1100, 2,   32'h7777_8888, 0,    3,   32'h7777_8888, 0};
        tbl[6] = '{0, 1, 0, 32'h0,         32'h0,         4'h0,  0, 32'h8000_0600, 32'h0,         4'hF,    0,   32'h0,         0,    256, 32'hDEAD_BEEF, 1};
        tbl[7] = '{1, 0, 0, 32'h8000_0040, 32'h0,         4'hF,  0, 32'h0,         32'h0,         4'h0,    255, 32'h0BAD_F00D, 1,    256, 32'h0BAD_F00D, 0};
        tbl[8] = '{0, 1, 0, 32'h0,         32'h0,         4'h0,  0, 32'h8000_0700, 32'h0,         4'hF,    1,   32'h5A5A_0001, 0,    2,   32'h5A5A_0001, 0};

        rst = 1'b1;
        clear_inputs();
        do_reset();

        for (int i = 0; i < 9; i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Both requesters held, memory always ready: D,D,D,D,I repeating, one grant per 3 cycles.
        do_reset();
        I_ibus_req = 1'b1; I_ibus_addr = 32'h0000_1000; I_ibus_mask = 4'hF;
        I_dbus_req = 1'b1; I_dbus_addr = 32'h0000_2000; I_dbus_mask = 4'hF;
        I_mem_ready = 1'b1;
        prev = 1'b0;
        g = 0;
        last = 0;
        for (int c = 1; c <= 60 && g < 10; c++) begin
            tick();
            if (O_mem_req && !prev) begin
                chk("streak_winner", 128'(O_mem_addr), 128'((g % 5 == 4) ? 32'h0000_1000 : 32'h0000_2000));
                if (g > 0) chk("streak_spacing", 128'(c - last), 128'(3));
                last = c;
                g++;
            end
            prev = O_mem_req;
        end
        chk("streak_count", 128'(g), 128'(10));
        clear_inputs();
        tick();
        tick();

        // Reset in the middle of a dbus grant.
        do_reset();
        I_dbus_req = 1'b1; I_dbus_addr = 32'h8000_0400; I_dbus_mask = 4'hF;
        tick();
        chk("rst_seq_mreq1", 128'(O_mem_req), 128'(1));
        tick();
        chk("rst_seq_mreq2", 128'(O_mem_req), 128'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_drop", 128'({O_mem_req, O_ibus_ready, O_dbus_ready, O_err}), 128'(0));
        I_dbus_req = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("rst_held_quiet", 128'({O_mem_req, O_ibus_ready, O_dbus_ready, O_err}), 128'(0));
        end
        rst = 1'b0;
        tick();
        chk("rst_release_quiet", 128'({O_mem_req, O_ibus_ready, O_dbus_ready, O_err}), 128'(0));
        fresh = '{1, 0, 0, 32'h8000_0000, 32'h0, 4'hF, 0, 32'h0, 32'h0, 4'h0, 2, 32'h600D_D00D, 1, 3, 32'h600D_D00D, 0};
        run_vec(fresh, "post_rst");

        // Random traffic against a timestamp-level model of the arbiter.
        do_reset();
        pend_i = 0; pend_d = 0; active = 0; win_i = 0; rdy = 0;
        exp_mreq = 0; exp_ir = 0; exp_dr = 0; exp_idata = 32'd0; exp_ddata = 32'd0; exp_pay = '0;
        avail = 0; dcnt = 0; gstart = 0; glat = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c > 0) begin
                tick();
                chk("rnd_mreq", 128'(O_mem_req), 128'(exp_mreq));
                if (exp_mreq) chk("rnd_payload", 128'({O_mem_we, O_mem_addr, O_mem_data, O_mem_mask}), 128'(exp_pay));
                chk("rnd_ready", 128'({O_ibus_ready, O_dbus_ready, O_err}), 128'({exp_ir, exp_dr, 1'b0}));
                chk("rnd_idata", 128'(O_ibus_data), 128'(exp_idata));
                chk("rnd_ddata", 128'(O_dbus_data), 128'(exp_ddata));
            end
            if (exp_ir) pend_i = 0;
            else if (!pend_i) begin
                rand_ipay();
                pend_i = ($urandom_range(2) == 0);
            end
            if (exp_dr) pend_d = 0;
            else if (!pend_d) begin
                rand_dpay();
                pend_d = ($urandom_range(2) == 0);
            end
            I_ibus_req = pend_i;
            I_dbus_req = pend_d;

            if (active) rdy = (c == gstart + glat);
            else rdy = 1'($urandom);
            I_mem_ready = rdy;
            I_mem_data  = $urandom;

            exp_ir = 0;
            exp_dr = 0;
            if (active) begin
                if (rdy) begin
                    exp_mreq = 0;
                    active   = 0;
                    avail    = c + 2;
                    if (win_i) begin
                        exp_ir = 1; exp_idata = I_mem_data;
                    end else begin
                        exp_dr = 1; exp_ddata = I_mem_data;
                    end
                end
            end else if (c >= avail && (pend_i || pend_d)) begin
                if (pend_i && pend_d) win_i = (dcnt == MAXS);
                else win_i = pend_i;
                if (win_i) dcnt = 0;
                else if (pend_i) dcnt = (dcnt < MAXS) ? dcnt + 1 : MAXS;
                exp_pay  = win_i ? {I_ibus_we, I_ibus_addr, I_ibus_data, I_ibus_mask}
                                 : {I_dbus_we, I_dbus_addr, I_dbus_data, I_dbus_mask};
                exp_mreq = 1;
                active   = 1;
                gstart   = c + 1;
                glat     = int'($urandom_range(4, 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
